// File: rtl/gol_display_pkg.sv
// Shared constants and types for the Game of Life display path.
// Used by the binary-to-BCD converter and its digit adjust cell.
package gol_display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [26:0] BCD_MAX = 27'd99_999_999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: values of 5 or more get +3.
// The result is at most 12, so four bits never carry out.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to 8-digit BCD converter.
// Digits update only on the completion edge; overflow saturates.
import gol_display_pkg::*;

module bin_to_bcd_seq #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4,
  output logic [3:0]       digit5,
  output logic [3:0]       digit6,
  output logic [3:0]       digit7,
  output logic [3:0]       digit8
);

  localparam int CW = 5;
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  localparam int SW = 4 * NUM_DIGITS;

  state_t           r_state;
  state_t           w_next;
  logic [BIN_W-1:0] r_bin;
  logic [SW-1:0]    r_scratch;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_pend;
  logic             r_done;
  logic             r_ovf;
  logic [SW-1:0]    r_digits;

  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_shift;
  logic             w_last;
  logic             w_accept;
  logic             w_ovf;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .i_nib (r_scratch[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  assign w_shift  = {w_adj[SW-2:0], r_bin[BIN_W-1]};
  assign w_last   = (r_cnt == LAST);
  assign w_accept = (r_state == IDLE) && start;
  assign w_ovf    = SW'(bin_in) > {5'd0, BCD_MAX};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: one pass of BIN_W shift cycles per request
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start)  w_next = SHIFT;
      SHIFT: if (w_last) w_next = IDLE;
    endcase
  end

  // Capture, shift/adjust datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin      <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_digits   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bin      <= bin_in;
        r_scratch  <= '0;
        r_cnt      <= '0;
        r_ovf_pend <= w_ovf;
      end else if (r_state == SHIFT) begin
        r_scratch <= w_shift;
        r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
        r_cnt     <= r_cnt + 1'b1;
        if (w_last) begin
          r_done   <= 1'b1;
          r_ovf    <= r_ovf_pend;
          r_digits <= r_ovf_pend ? {NUM_DIGITS{4'd9}} : w_shift;
        end
      end
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = r_done;
  assign overflow = r_ovf;
  assign digit1   = r_digits[3:0];
  assign digit2   = r_digits[7:4];
  assign digit3   = r_digits[11:8];
  assign digit4   = r_digits[15:12];
  assign digit5   = r_digits[19:16];
  assign digit6   = r_digits[23:20];
  assign digit7   = r_digits[27:24];
  assign digit8   = r_digits[31:28];

endmodule
